// File: rtl/seven_segment_scanner.sv
// Multiplexed 7-segment + DP display driver.
// Owns the digit scan timing, dead time between digits, PWM brightness and
// per-digit blink. New content arrives over a valid/ready handshake into a
// pending buffer and is promoted to the active buffer only at a frame
// boundary, so a frame is never drawn with mixed content.
module seven_segment_scanner #(
  parameter int   NUMBER_OF_DIGITS = 4,
  parameter logic CATHODE_COMMON   = 1'b1,
  parameter int   SCAN_DIVIDER     = 1000,
  parameter int   BLANK_CYCLES     = 16,
  parameter int   BRIGHTNESS_BITS  = 4,
  parameter int   BLINK_FRAMES     = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        update_valid,
  output logic                        update_ready,
  input  logic [5:0]                  digits [0:NUMBER_OF_DIGITS-1],
  input  logic [BRIGHTNESS_BITS-1:0]  brightness,
  input  logic [NUMBER_OF_DIGITS-1:0] blink_mask,
  output logic [7:0]                  segment_out,
  output logic [NUMBER_OF_DIGITS-1:0] digit_selector_out,
  output logic                        frame_done
);

  localparam int SLOT_W = $clog2(SCAN_DIVIDER);
  localparam int DIG_W  = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int FRM_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIVIDER - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUMBER_OF_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [31:0]       BLANK_U   = 32'(BLANK_CYCLES);

  localparam logic [7:0] SEG_OFF = CATHODE_COMMON ? 8'h00 : 8'hFF;
  localparam logic [NUMBER_OF_DIGITS-1:0] SEL_OFF =
    CATHODE_COMMON ? {NUMBER_OF_DIGITS{1'b1}} : {NUMBER_OF_DIGITS{1'b0}};

  // Hex nibble to {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Map an active-high segment pattern onto the board polarity.
  function automatic logic [7:0] seg_pins(input logic [7:0] s);
    seg_pins = CATHODE_COMMON ? s : ~s;
  endfunction

  // Map a one-hot (active-high) digit select onto the board polarity.
  function automatic logic [NUMBER_OF_DIGITS-1:0] sel_pins(
    input logic [NUMBER_OF_DIGITS-1:0] s);
    sel_pins = CATHODE_COMMON ? ~s : s;
  endfunction

  // Scan and blink state
  logic [SLOT_W-1:0] slot_count_q,  slot_count_d;
  logic [DIG_W-1:0]  digit_index_q, digit_index_d;
  logic [FRM_W-1:0]  frame_count_q, frame_count_d;
  logic              blink_phase_q, blink_phase_d;

  // Double buffer
  logic                        pend_flag_q, pend_flag_d;
  logic [5:0]                  pend_digits_q [0:NUMBER_OF_DIGITS-1];
  logic [5:0]                  pend_digits_d [0:NUMBER_OF_DIGITS-1];
  logic [BRIGHTNESS_BITS-1:0]  pend_bright_q, pend_bright_d;
  logic [NUMBER_OF_DIGITS-1:0] pend_blink_q,  pend_blink_d;
  logic [5:0]                  act_digits_q  [0:NUMBER_OF_DIGITS-1];
  logic [5:0]                  act_digits_d  [0:NUMBER_OF_DIGITS-1];
  logic [BRIGHTNESS_BITS-1:0]  act_bright_q,  act_bright_d;
  logic [NUMBER_OF_DIGITS-1:0] act_blink_q,   act_blink_d;

  // Registered pins
  logic [7:0]                  seg_q, seg_d;
  logic [NUMBER_OF_DIGITS-1:0] sel_q, sel_d;
  logic                        frame_done_q, frame_done_d;

  logic slot_wrap, frame_boundary, xfer;
  logic [5:0]                  cur_digit;
  logic [BRIGHTNESS_BITS-1:0]  on_low;
  logic [NUMBER_OF_DIGITS-1:0] onehot;
  logic                        in_blank, pwm_on, blinked, lit;

  // Slot/digit scan counters and the frame-based blink timer.
  always_comb begin
    slot_wrap      = (slot_count_q == SLOT_LAST);
    frame_boundary = slot_wrap && (digit_index_q == DIG_LAST);
    slot_count_d   = slot_wrap ? '0 : slot_count_q + 1'b1;
    digit_index_d  = digit_index_q;
    frame_count_d  = frame_count_q;
    blink_phase_d  = blink_phase_q;
    if (slot_wrap) begin
      digit_index_d = (digit_index_q == DIG_LAST) ? '0 : digit_index_q + 1'b1;
    end
    if (frame_boundary) begin
      if (frame_count_q == FRM_LAST) begin
        frame_count_d = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_count_d = frame_count_q + 1'b1;
      end
    end
  end

  // Handshake into pending; promote pending to active only on a frame boundary.
  always_comb begin
    xfer          = update_valid && !pend_flag_q;
    pend_flag_d   = pend_flag_q;
    pend_bright_d = pend_bright_q;
    pend_blink_d  = pend_blink_q;
    act_bright_d  = act_bright_q;
    act_blink_d   = act_blink_q;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      pend_digits_d[i] = pend_digits_q[i];
      act_digits_d[i]  = act_digits_q[i];
    end
    if (frame_boundary && pend_flag_q) begin
      pend_flag_d  = 1'b0;
      act_bright_d = pend_bright_q;
      act_blink_d  = pend_blink_q;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
        act_digits_d[i] = pend_digits_q[i];
      end
    end
    // A transfer can only happen while pending is empty, so it never
    // collides with the promotion above.
    if (xfer) begin
      pend_flag_d   = 1'b1;
      pend_bright_d = brightness;
      pend_blink_d  = blink_mask;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
        pend_digits_d[i] = digits[i];
      end
    end
  end

  // Decide whether the current digit is lit this clock and build the pin values.
  always_comb begin
    cur_digit = act_digits_q[digit_index_q];
    in_blank  = (32'(slot_count_q) < BLANK_U);
    // Difference is only meaningful outside the dead time; low bits drive the PWM.
    on_low    = BRIGHTNESS_BITS'(32'(slot_count_q) - BLANK_U);
    pwm_on    = (on_low < act_bright_q);
    blinked   = act_blink_q[digit_index_q] && blink_phase_q;
    lit       = !in_blank && pwm_on && cur_digit[5] && !blinked;
    onehot    = NUMBER_OF_DIGITS'(1) << digit_index_q;
    seg_d     = SEG_OFF;
    sel_d     = SEL_OFF;
    if (lit) begin
      seg_d = seg_pins({cur_digit[4], hex_to_seg(cur_digit[3:0])});
      sel_d = sel_pins(onehot);
    end
    frame_done_d = frame_boundary;
  end

  // Scan counters and blink state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_count_q  <= '0;
      digit_index_q <= '0;
      frame_count_q <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      slot_count_q  <= slot_count_d;
      digit_index_q <= digit_index_d;
      frame_count_q <= frame_count_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Pending and active display buffers; reset leaves every digit disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_flag_q   <= 1'b0;
      pend_bright_q <= '0;
      pend_blink_q  <= '0;
      act_bright_q  <= '0;
      act_blink_q   <= '0;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
        pend_digits_q[i] <= '0;
        act_digits_q[i]  <= '0;
      end
    end else begin
      pend_flag_q   <= pend_flag_d;
      pend_bright_q <= pend_bright_d;
      pend_blink_q  <= pend_blink_d;
      act_bright_q  <= act_bright_d;
      act_blink_q   <= act_blink_d;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
        pend_digits_q[i] <= pend_digits_d[i];
        act_digits_q[i]  <= act_digits_d[i];
      end
    end
  end

  // Output registers so the pins are glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_q        <= SEG_OFF;
      sel_q        <= SEL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign update_ready       = !pend_flag_q;
  assign segment_out        = seg_q;
  assign digit_selector_out = sel_q;
  assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: a common-cathode and a common-anode copy
// run from the same stimulus against a cycle-indexed reference model.
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int SD    = 32;
  localparam int BC    = 4;
  localparam int BB    = 2;
  localparam int BF    = 2;
  localparam int FRAME = SD * N;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         update_valid = 1'b0;
  logic [5:0]   digits [0:N-1];
  logic [BB-1:0] brightness = '0;
  logic [N-1:0] blink_mask = '0;

  logic         update_ready, frame_done;
  logic [7:0]   segment_out;
  logic [N-1:0] digit_selector_out;
  logic         update_ready_n, frame_done_n;
  logic [7:0]   segment_out_n;
  logic [N-1:0] digit_selector_out_n;

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS(N), .CATHODE_COMMON(1'b1), .SCAN_DIVIDER(SD),
    .BLANK_CYCLES(BC), .BRIGHTNESS_BITS(BB), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .update_valid(update_valid),
    .update_ready(update_ready), .digits(digits), .brightness(brightness),
    .blink_mask(blink_mask), .segment_out(segment_out),
    .digit_selector_out(digit_selector_out), .frame_done(frame_done)
  );

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS(N), .CATHODE_COMMON(1'b0), .SCAN_DIVIDER(SD),
    .BLANK_CYCLES(BC), .BRIGHTNESS_BITS(BB), .BLINK_FRAMES(BF)
  ) dut_ca (
    .clock(clock), .reset_n(reset_n), .update_valid(update_valid),
    .update_ready(update_ready_n), .digits(digits), .brightness(brightness),
    .blink_mask(blink_mask), .segment_out(segment_out_n),
    .digit_selector_out(digit_selector_out_n), .frame_done(frame_done_n)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]   seg;
    logic [N-1:0] sel;
    logic         fd;
    logic         rdy;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state, indexed by clocks since reset release.
  int            cyc;
  bit            m_pend, m_xfer;
  int            m_xfer_cyc;
  logic [5:0]    m_pd [0:N-1];
  logic [5:0]    m_ad [0:N-1];
  logic [BB-1:0] m_pb, m_ab;
  logic [N-1:0]  m_pm, m_am;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_pend = 0; m_xfer = 0; m_xfer_cyc = -1;
    m_pb = '0; m_ab = '0; m_pm = '0; m_am = '0;
    for (int i = 0; i < N; i++) begin
      m_pd[i] = '0;
      m_ad[i] = '0;
    end
  endtask

  // One clock: predict the registered pins produced by this edge, queue them,
  // then advance the model's handshake state.
  task automatic tick();
    int   slot, dg, fr;
    bit   ph, lit;
    exp_t e;
    @(posedge clock);
    slot = cyc % SD;
    dg   = (cyc / SD) % N;
    fr   = cyc / FRAME;
    ph   = ((fr / BF) % 2) == 1;
    lit  = (slot >= BC) && (((slot - BC) % (1 << BB)) < int'(m_ab))
           && (m_ad[dg][5] == 1'b1) && !(m_am[dg] && ph);
    e.seg = lit ? {m_ad[dg][4], pat_tab[m_ad[dg][3:0]]} : 8'h00;
    e.sel = lit ? ~(4'b0001 << dg) : 4'hF;
    e.fd  = (cyc % FRAME) == FRAME - 1;
    m_xfer = update_valid && !m_pend;
    if (e.fd && m_pend) begin
      for (int i = 0; i < N; i++) m_ad[i] = m_pd[i];
      m_ab = m_pb; m_am = m_pm; m_pend = 0;
    end
    if (m_xfer) begin
      for (int i = 0; i < N; i++) m_pd[i] = digits[i];
      m_pb = brightness; m_pm = blink_mask; m_pend = 1; m_xfer_cyc = cyc;
    end
    e.rdy = !m_pend;
    sbq.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge to be processed has the given in-frame position.
  task automatic wait_until(input int pos);
    int n = 0;
    while ((cyc % FRAME) != pos && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  // Present content and hold it until it is taken (bounded).
  task automatic offer(input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2,
                       input logic [5:0] d3, input logic [BB-1:0] br, input logic [N-1:0] bm,
                       output int acc);
    int n = 0;
    digits[0] = d0; digits[1] = d1; digits[2] = d2; digits[3] = d3;
    brightness = br; blink_mask = bm; update_valid = 1'b1;
    acc = -1;
    while (acc < 0 && n < 4 * FRAME) begin
      tick();
      n++;
      if (m_xfer) acc = m_xfer_cyc;
    end
    update_valid = 1'b0;
    check_val("offer_taken", 32'(acc >= 0), 32'd1);
  endtask

  // Count lit clocks over one full frame straight from the pins; also count digit 0.
  task automatic count_lit(output int all_lit, output int d0_lit);
    all_lit = 0; d0_lit = 0;
    wait_until(0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (digit_selector_out != 4'hF) all_lit++;
      if (digit_selector_out == 4'hE) d0_lit++;
    end
  endtask

  task automatic check_off(input string tag);
    check_val({tag, "_seg"},   32'(segment_out),          32'h00);
    check_val({tag, "_sel"},   32'(digit_selector_out),   32'hF);
    check_val({tag, "_rdy"},   32'(update_ready),         32'd1);
    check_val({tag, "_fd"},    32'(frame_done),           32'd0);
    check_val({tag, "_seg_n"}, 32'(segment_out_n),        32'hFF);
    check_val({tag, "_sel_n"}, 32'(digit_selector_out_n), 32'h0);
  endtask

  // Scoreboard: pop one prediction per clock and compare away from the edge.
  initial begin
    exp_t         e;
    logic [7:0]   iseg;
    logic [N-1:0] isel;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        iseg = ~e.seg;
        isel = ~e.sel;
        check_val("seg",   32'(segment_out),          32'(e.seg));
        check_val("sel",   32'(digit_selector_out),   32'(e.sel));
        check_val("fd",    32'(frame_done),           32'(e.fd));
        check_val("rdy",   32'(update_ready),         32'(e.rdy));
        check_val("seg_n", 32'(segment_out_n),        32'(iseg));
        check_val("sel_n", 32'(digit_selector_out_n), 32'(isel));
        check_val("fd_n",  32'(frame_done_n),         32'(e.fd));
        check_val("rdy_n", 32'(update_ready_n),       32'(e.rdy));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_b, all_lit, d0_lit;
    bit ph;
    for (int i = 0; i < N; i++) digits[i] = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_off("reset");
    reset_n = 1'b1;

    // Idle after reset: blank display, frame_done every FRAME clocks.
    run(4 * FRAME);

    // First content update mid-frame.
    wait_until(50);
    offer(6'h21, 6'h32, 6'h20, 6'h0F, 2'd3, 4'b0000, acc);
    check_val("ready_drop", 32'(update_ready), 32'd0);
    wait_until(0);
    check_val("ready_back", 32'(update_ready), 32'd1);
    count_lit(all_lit, d0_lit);
    check_val("lit_br3", 32'(all_lit), 32'd63);
    check_val("lit_br3_d0", 32'(d0_lit), 32'd21);

    // Brightness 0 then 1.
    offer(6'h21, 6'h32, 6'h20, 6'h0F, 2'd0, 4'b0000, acc);
    count_lit(all_lit, d0_lit);
    check_val("lit_br0", 32'(all_lit), 32'd0);
    offer(6'h21, 6'h32, 6'h20, 6'h0F, 2'd1, 4'b0000, acc);
    count_lit(all_lit, d0_lit);
    check_val("lit_br1", 32'(all_lit), 32'd21);

    // Blink digit 0; phase follows the frame count since reset.
    offer(6'h21, 6'h32, 6'h20, 6'h0F, 2'd3, 4'b0001, acc);
    for (int f = 0; f < 5; f++) begin
      count_lit(all_lit, d0_lit);
      ph = (((cyc - 1) / FRAME / BF) % 2) == 1;
      check_val("blink_d0", 32'(d0_lit), ph ? 32'd0 : 32'd21);
      check_val("blink_all", 32'(all_lit), ph ? 32'd42 : 32'd63);
    end

    // Back-to-back offers: the second waits for the boundary.
    offer(6'h00, 6'h00, 6'h00, 6'h00, 2'd0, 4'b0000, acc);
    wait_until(0);
    wait_until(40);
    offer(6'h25, 6'h2A, 6'h3C, 6'h2E, 2'd2, 4'b0000, acc);
    offer(6'h28, 6'h29, 6'h2B, 6'h2D, 2'd3, 4'b0000, acc_b);
    check_val("b2b_accept_pos", 32'(acc_b % FRAME), 32'd0);
    check_val("b2b_after_first", 32'(acc_b > acc), 32'd1);
    wait_until(0);

    // Offer exactly on the boundary cycle: applied one frame later.
    wait_until(FRAME - 1);
    offer(6'h37, 6'h26, 6'h24, 6'h23, 2'd3, 4'b0000, acc);
    check_val("bnd_accept_pos", 32'(acc % FRAME), 32'(FRAME - 1));
    run(2 * FRAME);

    // Reset mid-slot with an update pending.
    wait_until(70);
    offer(6'h21, 6'h32, 6'h20, 6'h0F, 2'd3, 4'b0000, acc);
    run(10);
    #6;
    reset_n = 1'b0;
    #1;
    check_off("async_rst");
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_off("rst_hold");
    reset_n = 1'b1;
    run(2 * FRAME);
    check_val("post_rst_ready", 32'(update_ready), 32'd1);

    // Repeat the first update after reset; both polarities are scored.
    wait_until(20);
    offer(6'h21, 6'h32, 6'h20, 6'h0F, 2'd3, 4'b0000, acc);
    count_lit(all_lit, d0_lit);
    check_val("lit_rep", 32'(all_lit), 32'd63);
    run(4);

    @(negedge clock);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Self-timed multiplexed 7-segment + DP display driver: owns digit scan timing, anti-ghosting dead time, PWM brightness, per-digit blink, and tear-free double-buffered update via valid/ready handshake.
- Input digit format: 6 bits = {enable, dp, hex[3:0]}.
- Sits between application logic and board pins; no external scan strobe required.

Parameters:
- NUMBER_OF_DIGITS, 4: digits scanned (>=1).
- CATHODE_COMMON, 1'b1: 1 = segments active-high, selectors active-low; 0 = both inverted.
- SCAN_DIVIDER, 1000: clocks per digit slot (>=2).
- BLANK_CYCLES, 16: dead-time clocks at start of each slot (< SCAN_DIVIDER).
- BRIGHTNESS_BITS, 4: brightness width (>=1).
- BLINK_FRAMES, 64: frames per blink half-period (>=1).

Ports:
- clock  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- update_valid  in  1  new display content offered.
- update_ready  out  1  block can accept content.
- digits  in  6 x NUMBER_OF_DIGITS (unpacked [0:N-1])  {enable, dp, hex}.
- brightness  in  BRIGHTNESS_BITS  duty setting, captured with digits.
- blink_mask  in  NUMBER_OF_DIGITS  digits to blink, captured with digits.
- segment_out  out  8  {dp,g,f,e,d,c,b,a}, polarity per CATHODE_COMMON.
- digit_selector_out  out  NUMBER_OF_DIGITS  bit i selects digit i, polarity per CATHODE_COMMON.
- frame_done  out  1  one-clock pulse per completed frame.

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-low. While reset_n=0:
  - all counters = 0; active and pending buffers = 0 (all digits disabled); pending flag = 0; blink_phase = 0.
  - update_ready = 1, frame_done = 0.
  - segment_out and digit_selector_out at their off level.
- Off level:
  - CATHODE_COMMON=1: segments 8'h00, selectors all ones.
  - CATHODE_COMMON=0: segments 8'hFF, selectors all zeros.
- Counters:
  - slot_count: 0..SCAN_DIVIDER-1.
  - digit_index: 0..N-1, advances when slot_count wraps; digit 0 scanned first.
  - Frame boundary = cycle with slot_count=SCAN_DIVIDER-1 and digit_index=N-1.
- Per slot:
  - slot_count < BLANK_CYCLES: off level (dead time).
  - Otherwise, with on_count = slot_count - BLANK_CYCLES, digit is lit iff on_count[BRIGHTNESS_BITS-1:0] < active brightness.
    - brightness 0 = dark.
    - Max brightness gives (2^B - 1)/2^B duty.
- Lit digit:
  - selector bit digit_index asserted, all others deasserted.
  - Segments = hex pattern with DP in bit 7: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - If the digit's enable=0, or its blink_mask bit=1 and blink_phase=1: off level, but the slot still elapses.
- Outputs are registered: pins reflect the counter state one clock earlier.
- frame_done: asserted the cycle after the frame boundary, registered.
- Blink: frame counter counts frame boundaries; blink_phase toggles on each BLINK_FRAMES-th boundary, then the counter clears.
- Handshake:
  - Transfer when update_valid & update_ready.
  - On transfer: digits, brightness, and blink_mask latched into pending; pending flag set; update_ready=0 from the next cycle.
  - At the next frame boundary with pending set: pending copied to active, flag cleared, update_ready=1 on the following cycle.
  - Active content never changes mid-frame.
- Transfer on the frame-boundary cycle itself: goes to pending and is applied at the following boundary.
- update_valid while update_ready=0: ignored; the offering side must hold until accepted.
- Reset mid-frame or mid-handshake: pending content discarded; display blank until the first post-reset update reaches active.

Test Plan (N=4, SCAN_DIVIDER=32, BLANK_CYCLES=4, BRIGHTNESS_BITS=2, BLINK_FRAMES=2, CATHODE_COMMON=1):
- Reset release, no update: segment_out=00, digit_selector_out=F for 4 frames; update_ready=1; frame_done pulses every 128 clocks.
- Update digits={0x21,0x32,0x20,0x0F}, brightness=3, mid-frame:
  - update_ready drops next cycle.
  - Content unchanged until the boundary, then ready=1 again.
  - Next frame: digit0 slot shows selector=E, segments=06 for 3 of every 4 on-cycles after 4 blank cycles.
  - digit1 shows 5B|80=DB.
  - digit2 shows 3F.
  - digit3 (enable=0) stays off.
- brightness=0 update: all outputs off for a full frame; brightness=1: exactly 7 lit clocks per slot (on_count mod 4 = 0 over 28 on-cycles).
- blink_mask=4'b0001, digit0 enabled: digit0 lit frames 0-1, dark frames 2-3, lit 4-5; other digits unaffected.
- Back-to-back offers: second update_valid held while ready=0 is not accepted until after the boundary.
  - Update offered exactly on the boundary cycle: applied one frame later.
- Assert reset_n=0 mid-slot with pending update: outputs immediately off (async); after release, display blank and ready=1.
- Repeat the first update with CATHODE_COMMON=0: all segment and selector values bitwise inverted.
